// File: rtl/status_reg_pkg.sv
// Shared definitions for the 6502 processor status register (P):
// bit positions, the reset image and a helper that assembles the byte.
package status_reg_pkg;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  // I=1 and the two unstored bits (5,4) read as 1.
  localparam logic [7:0] RESET_P_DEFAULT = 8'h34;

  // Assemble a P byte. Bit 5 always reads 1; bit 4 is caller supplied.
  function automatic logic [7:0] pack_p(input logic n, input logic v, input logic b,
                                        input logic d, input logic i, input logic z,
                                        input logic c);
    pack_p = {n, v, 1'b1, b, d, i, z, c};
  endfunction

endpackage

// File: rtl/status_flag.sv
// One status flag: 1-bit register with synchronous reset value and a fixed
// priority of update sources: priority load > set > clear > low load > hold.
module status_flag #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pri_ld,
  input  logic pri_d,
  input  logic set,
  input  logic clr,
  input  logic ld,
  input  logic d,
  output logic q
);

  // Prioritised update; reset discards every pending source.
  always_ff @(posedge clk) begin
    if (reset)       q <= RST_VAL;
    else if (pri_ld) q <= pri_d;
    else if (set)    q <= 1'b1;
    else if (clr)    q <= 1'b0;
    else if (ld)     q <= d;
  end

endmodule

// File: rtl/status_reg.sv
// 6502 status register. Each flag is a status_flag instance; this level muxes
// the bus/BIT/alu sources per flag and forms the observe and push buses.
// The IRQ mask seen by the interrupt sequencer lags I by one cycle.
module status_reg
  import status_reg_pkg::*;
#(
  parameter logic [7:0] RESET_P = RESET_P_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       aluCout,
  input  logic       aluZero,
  input  logic       aluOverflow,
  input  logic       aluNeg,
  input  logic [7:0] dbIn,
  input  logic       loadNZ,
  input  logic       loadC,
  input  logic       loadV,
  input  logic       loadDb,
  input  logic       bitLoad,
  input  logic       setC,
  input  logic       clrC,
  input  logic       setI,
  input  logic       clrI,
  input  logic       setD,
  input  logic       clrD,
  input  logic       clrV,
  input  logic       brkFlag,
  input  logic       dbOe,
  output logic       carry,
  output logic       decimal,
  output logic       irqMask,
  output logic [7:0] pOut,
  output logic [7:0] dbOut
);

  logic c_q, z_q, i_q, d_q, v_q, n_q;
  logic nzv_pri_ld;
  logic z_pri_d;
  logic unused_db;

  // Bits 5 and 4 of a pulled byte are not stored.
  assign unused_db = ^dbIn[P_U:P_B];

  // BIT shares the top load slot with the bus load; the bus load wins.
  assign nzv_pri_ld = loadDb | bitLoad;
  assign z_pri_d    = loadDb ? dbIn[P_Z] : aluZero;

  status_flag #(.RST_VAL(RESET_P[P_C])) u_c (
    .clk(clk), .reset(reset), .pri_ld(loadDb), .pri_d(dbIn[P_C]),
    .set(setC), .clr(clrC), .ld(loadC), .d(aluCout), .q(c_q));

  status_flag #(.RST_VAL(RESET_P[P_Z])) u_z (
    .clk(clk), .reset(reset), .pri_ld(nzv_pri_ld), .pri_d(z_pri_d),
    .set(1'b0), .clr(1'b0), .ld(loadNZ), .d(aluZero), .q(z_q));

  // N and V come from the same dbIn bit for both bus load and BIT.
  status_flag #(.RST_VAL(RESET_P[P_N])) u_n (
    .clk(clk), .reset(reset), .pri_ld(nzv_pri_ld), .pri_d(dbIn[P_N]),
    .set(1'b0), .clr(1'b0), .ld(loadNZ), .d(aluNeg), .q(n_q));

  status_flag #(.RST_VAL(RESET_P[P_V])) u_v (
    .clk(clk), .reset(reset), .pri_ld(nzv_pri_ld), .pri_d(dbIn[P_V]),
    .set(1'b0), .clr(clrV), .ld(loadV), .d(aluOverflow), .q(v_q));

  status_flag #(.RST_VAL(RESET_P[P_I])) u_i (
    .clk(clk), .reset(reset), .pri_ld(loadDb), .pri_d(dbIn[P_I]),
    .set(setI), .clr(clrI), .ld(1'b0), .d(1'b0), .q(i_q));

  status_flag #(.RST_VAL(RESET_P[P_D])) u_d (
    .clk(clk), .reset(reset), .pri_ld(loadDb), .pri_d(dbIn[P_D]),
    .set(setD), .clr(clrD), .ld(1'b0), .d(1'b0), .q(d_q));

  // Mask follows I one cycle late so the instruction after CLI is still masked.
  always_ff @(posedge clk) begin
    if (reset) irqMask <= 1'b1;
    else       irqMask <= i_q;
  end

  // Outputs are combinational from current flags; a push sees pre-update P.
  assign carry   = c_q;
  assign decimal = d_q;
  assign pOut    = pack_p(n_q, v_q, 1'b1, d_q, i_q, z_q, c_q);
  assign dbOut   = dbOe ? pack_p(n_q, v_q, brkFlag, d_q, i_q, z_q, c_q) : 8'h00;

endmodule

// File: tb/tb_status_reg.sv
// Bench for status_reg: a reference model pushes expected outputs per clock to
// a queue; they are popped and compared #1 after the edge. Directed cases also
// check fixed constants.
module tb_status_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic       aluCout, aluZero, aluOverflow, aluNeg;
  logic [7:0] dbIn;
  logic       loadNZ, loadC, loadV, loadDb, bitLoad;
  logic       setC, clrC, setI, clrI, setD, clrD, clrV;
  logic       brkFlag, dbOe;
  logic       carry, decimal, irqMask;
  logic [7:0] pOut, dbOut;

  int total = 0;
  int bad   = 0;

  // expected word: {pOut, dbOut, carry, decimal, irqMask}
  logic [18:0] exp_q[$];

  // reference model state
  logic m_n = 0, m_v = 0, m_d = 0, m_i = 0, m_z = 0, m_c = 0, m_irq = 0;

  status_reg dut (
    .clk(clk), .reset(reset), .aluCout(aluCout), .aluZero(aluZero),
    .aluOverflow(aluOverflow), .aluNeg(aluNeg), .dbIn(dbIn), .loadNZ(loadNZ),
    .loadC(loadC), .loadV(loadV), .loadDb(loadDb), .bitLoad(bitLoad),
    .setC(setC), .clrC(clrC), .setI(setI), .clrI(clrI), .setD(setD),
    .clrD(clrD), .clrV(clrV), .brkFlag(brkFlag), .dbOe(dbOe),
    .carry(carry), .decimal(decimal), .irqMask(irqMask), .pOut(pOut),
    .dbOut(dbOut));

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    reset = 0; aluCout = 0; aluZero = 0; aluOverflow = 0; aluNeg = 0; dbIn = 8'h00;
    loadNZ = 0; loadC = 0; loadV = 0; loadDb = 0; bitLoad = 0;
    setC = 0; clrC = 0; setI = 0; clrI = 0; setD = 0; clrD = 0; clrV = 0;
    brkFlag = 0; dbOe = 0;
  endtask

  // Advance the model by one clock from the current inputs, push its outputs,
  // clock the DUT and compare after the edge.
  task automatic tick();
    logic [18:0] e, g;
    logic [7:0]  e_db;
    logic        nn, nv, nd, ni, nz, nc;
    if (reset) begin
      {nn, nv, nd, ni, nz, nc} = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    end else begin
      nc = loadDb ? dbIn[0] : setC ? 1'b1 : clrC ? 1'b0 : loadC ? aluCout : m_c;
      nz = loadDb ? dbIn[1] : bitLoad ? aluZero : loadNZ ? aluZero : m_z;
      nn = loadDb ? dbIn[7] : bitLoad ? dbIn[7] : loadNZ ? aluNeg : m_n;
      nv = loadDb ? dbIn[6] : bitLoad ? dbIn[6] : clrV ? 1'b0 : loadV ? aluOverflow : m_v;
      ni = loadDb ? dbIn[2] : setI ? 1'b1 : clrI ? 1'b0 : m_i;
      nd = loadDb ? dbIn[3] : setD ? 1'b1 : clrD ? 1'b0 : m_d;
    end
    m_irq = reset ? 1'b1 : m_i;
    {m_n, m_v, m_d, m_i, m_z, m_c} = {nn, nv, nd, ni, nz, nc};
    e_db = dbOe ? {m_n, m_v, 1'b1, brkFlag, m_d, m_i, m_z, m_c} : 8'h00;
    exp_q.push_back({m_n, m_v, 2'b11, m_d, m_i, m_z, m_c, e_db, m_c, m_d, m_irq});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    g = {pOut, dbOut, carry, decimal, irqMask};
    check("sb_pOut",    g[18:11], e[18:11]);
    check("sb_dbOut",   g[10:3],  e[10:3]);
    check("sb_carry",   g[2],     e[2]);
    check("sb_decimal", g[1],     e[1]);
    check("sb_irqMask", g[0],     e[0]);
  endtask

  initial begin
    idle_inputs();
    @(posedge clk); #1;

    // 1. reset for two cycles, then idle
    reset = 1; tick(); tick();
    check("rst_pOut", pOut, 8'h34);
    check("rst_irq", irqMask, 1'b1);
    check("rst_carry", carry, 1'b0);
    check("rst_decimal", decimal, 1'b0);
    check("rst_dbOut", dbOut, 8'h00);
    reset = 0; tick(); tick();
    check("idle_pOut", pOut, 8'h34);

    // 2. alu 0x0F+0x01 result loads, then negative with carry
    loadNZ = 1; loadC = 1; tick();
    check("alu1_pOut", pOut, 8'h34);
    aluNeg = 1; aluCout = 1; tick();
    check("alu2_pOut", pOut, 8'hB5);
    idle_inputs();

    // 3. bus load of FF, push with B=0 and B=1
    dbIn = 8'hFF; loadDb = 1; tick();
    check("plp_pOut", pOut, 8'hFF);
    idle_inputs();
    dbOe = 1; brkFlag = 0; #1;
    check("push_irq", dbOut, 8'hEF);
    brkFlag = 1; #1;
    check("push_brk", dbOut, 8'hFF);
    // push concurrent with a load shows the pre-update value
    dbIn = 8'h00; loadDb = 1; #1;
    check("push_pre", dbOut, 8'hFF);
    tick();
    check("push_post", dbOut, 8'h30);
    idle_inputs();

    // 4. CLI latency and set-wins
    setI = 1; tick(); tick(); idle_inputs();
    clrI = 1; tick(); idle_inputs();
    check("cli_t1_i", pOut[2], 1'b0);
    check("cli_t1_mask", irqMask, 1'b1);
    tick();
    check("cli_t2_mask", irqMask, 1'b0);
    setI = 1; clrI = 1; tick(); idle_inputs();
    check("seti_wins", pOut[2], 1'b1);

    // 5. BIT overrides loadNZ and clrV
    bitLoad = 1; dbIn = 8'h40; aluZero = 1; aluNeg = 1; loadNZ = 1; clrV = 1; tick();
    idle_inputs();
    check("bit_n", pOut[7], 1'b0);
    check("bit_v", pOut[6], 1'b1);
    check("bit_z", pOut[1], 1'b1);

    // 6. reset beats concurrent strobes
    setD = 1; loadC = 1; aluCout = 1; reset = 1; tick(); idle_inputs();
    check("rst_wins", pOut, 8'h34);
    setD = 1; tick(); idle_inputs();
    check("sed_decimal", decimal, 1'b1);

    // randomised strobes against the model
    for (int k = 0; k < 300; k++) begin
      reset       = ($urandom_range(0, 31) == 0);
      aluCout     = $urandom_range(0, 1);
      aluZero     = $urandom_range(0, 1);
      aluOverflow = $urandom_range(0, 1);
      aluNeg      = $urandom_range(0, 1);
      dbIn        = 8'($urandom_range(0, 255));
      loadNZ      = ($urandom_range(0, 3) == 0);
      loadC       = ($urandom_range(0, 3) == 0);
      loadV       = ($urandom_range(0, 3) == 0);
      loadDb      = ($urandom_range(0, 7) == 0);
      bitLoad     = ($urandom_range(0, 7) == 0);
      setC        = ($urandom_range(0, 4) == 0);
      clrC        = ($urandom_range(0, 4) == 0);
      setI        = ($urandom_range(0, 4) == 0);
      clrI        = ($urandom_range(0, 4) == 0);
      setD        = ($urandom_range(0, 4) == 0);
      clrD        = ($urandom_range(0, 4) == 0);
      clrV        = ($urandom_range(0, 4) == 0);
      brkFlag     = $urandom_range(0, 1);
      dbOe        = $urandom_range(0, 1);
      tick();
    end

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
